instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction decoder. It holds the program counter and issues reads to the synchronous program memory, which has 1-cycle read latency. It latches the returned 16-bit word into the instruction register and presents it to the decoder and control path with a valid/ready handshake. It also accepts branch/jump redirects from the execute stage.

Parameters:
WIDTH, 16, instruction/data word width in bits
ADDR_BITS, 16, program counter / memory address width
RESET_PC, 0, PC value loaded on reset (ADDR_BITS wide)

Ports:
clk  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
fetch_en  input  1  permits new fetches; low holds the FSM in IDLE/FETCH without a memory read
mem_addr  output  ADDR_BITS  program memory read address
mem_rd_en  output  1  memory read strobe; data valid on mem_rdata exactly one cycle later
mem_rdata  input  WIDTH  program memory read data
redirect  input  1  branch/jump taken; flush and refetch from redirect_pc
redirect_pc  input  ADDR_BITS  redirect target address
instr_out  output  WIDTH  latched instruction word to the decoder
instr_pc  output  ADDR_BITS  address the instr_out word was fetched from
instr_pc_plus1  output  ADDR_BITS  instr_pc + 1, modulo 2^ADDR_BITS (link value for jal)
instr_valid  output  1  instr_out holds a valid, unconsumed instruction
instr_ready  input  1  consumer accepts instr_out this cycle

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset). When reset is high at a clk edge: state=IDLE, pc=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0. reset overrides every other input.
- mem_rd_en and mem_addr are combinational from state/pc. mem_rd_en=1 only in FETCH with fetch_en=1. mem_addr=pc at all times.
- instr_pc_plus1 is combinational: instr_pc+1, wrapping 0xFFFF->0x0000 for ADDR_BITS=16.
- States: IDLE, FETCH, WAIT, HOLD.
- IDLE: no read. Next state is FETCH if fetch_en=1, otherwise IDLE.
- FETCH: read issued with mem_addr=pc. Next state is WAIT if fetch_en=1, otherwise FETCH with no read.
- WAIT: mem_rdata is valid this cycle. At the edge: instr_out<=mem_rdata, instr_pc<=pc, pc<=pc+1 (mod 2^ADDR_BITS), instr_valid<=1, next state HOLD.
- HOLD: instr_valid=1 and instr_out stable.
  - instr_ready=1: instr_valid<=0, next state FETCH.
  - instr_ready=0: remain in HOLD; all outputs unchanged.
- Redirect has priority over every transition in FETCH, WAIT and HOLD:
  - pc<=redirect_pc, instr_valid<=0, next state FETCH.
  - In WAIT, the returning mem_rdata is discarded and instr_out keeps its old value.
  - In HOLD with instr_ready=1 in the same cycle, the instruction counts as consumed and the redirect is still applied.
  - In IDLE: pc<=redirect_pc and the state follows the IDLE rule.
- A read issued in FETCH is never cancelled. A redirect in the following WAIT only suppresses the capture.
- Throughput: one instruction every 3 cycles when instr_ready is held high (FETCH, WAIT, HOLD).
- Latency: instr_valid rises 2 cycles after the FETCH cycle.
- fetch_en low while in WAIT or HOLD has no effect; the in-flight word is still captured and held.
- redirect_pc is used as-is at ADDR_BITS width; no alignment checks.
- Reset mid-WAIT: the in-flight data is dropped, instr_valid=0, and fetching restarts from RESET_PC via IDLE.

Test Plan:
- Reset then fetch_en=1, memory[0]=0x0A12, instr_ready=1 -> mem_rd_en high 1 cycle after reset deasserts with mem_addr=0x0000; instr_valid high 2 cycles later with instr_out=0x0A12, instr_pc=0x0000, instr_pc_plus1=0x0001.
- Sequential stream, memory[0..3]=0x1111,0x2222,0x3333,0x4444, instr_ready=1 -> words delivered in order, one every 3 cycles; instr_pc 0,1,2,3.
- Backpressure: instr_ready=0 for 5 cycles in HOLD with word 0x2222 -> instr_valid stays 1, instr_out stays 0x2222, mem_rd_en stays 0; after ready=1, the next fetch is at address 0x0002.
- Redirect in WAIT to 0x0040 (memory[0x40]=0xC0DE) -> the WAIT-cycle data is not captured; the next mem_addr is 0x0040 and the next delivered word is 0xC0DE with instr_pc=0x0040.
- Redirect in HOLD with instr_ready=0, target 0x0010 -> instr_valid drops next cycle and the next read is at 0x0010; repeat with instr_ready=1 in the same cycle -> same result.
- Wrap and reset: pc at 0xFFFF fetches memory[0xFFFF] -> instr_pc_plus1=0x0000 and the next read is at 0x0000. Asserting reset during WAIT -> instr_valid=0 and the next read is at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage sitting directly in front of the instruction decoder. It holds
// the program counter and issues reads to a synchronous program memory with
// 1-cycle read latency. It latches the returned word into the instruction
// register and hands it to the decoder with a valid/ready handshake. Branch
// and jump redirects from the execute stage flush the stage and restart
// fetching at the target.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   fetch_en       permits new memory reads
//   mem_addr       program memory read address (always the current pc)
//   mem_rd_en      read strobe, data appears on mem_rdata one cycle later
//   mem_rdata      program memory read data
//   redirect       branch/jump taken: flush and refetch from redirect_pc
//   redirect_pc    redirect target address
//   instr_out      latched instruction word
//   instr_pc       address instr_out was fetched from
//   instr_pc_plus1 instr_pc + 1, wrapping (link value for jal)
//   instr_valid    instr_out holds a valid, unconsumed instruction
//   instr_ready    consumer accepts instr_out this cycle
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int unsigned            WIDTH     = 16,
  parameter int unsigned            ADDR_BITS = 16,
  parameter logic [ADDR_BITS-1:0]   RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic                 redirect,
  input  logic [ADDR_BITS-1:0] redirect_pc,
  output logic [WIDTH-1:0]     instr_out,
  output logic [ADDR_BITS-1:0] instr_pc,
  output logic [ADDR_BITS-1:0] instr_pc_plus1,
  output logic                 instr_valid,
  input  logic                 instr_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] PC_ONE = ADDR_BITS'(1);

  state_t               state;
  logic [ADDR_BITS-1:0] pc;

  // The read strobe is decoded straight from the state so the memory sees the
  // request in the same cycle the FSM is in FETCH; the data lands in WAIT.
  assign mem_rd_en      = (state == FETCH) && fetch_en;
  assign mem_addr       = pc;
  assign instr_pc_plus1 = instr_pc + PC_ONE;

  // NOTE: every register here is updated with non-blocking assignments so all
  // right-hand sides see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // A redirect while idle only retargets the pc; the state still
          // follows fetch_en.
          if (redirect) pc <= redirect_pc;
          state <= fetch_en ? FETCH : IDLE;
        end

        FETCH: begin
          if (redirect) begin
            // Any read issued this cycle still completes; its data returns
            // while we sit in FETCH again and is simply never captured.
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else begin
            state <= fetch_en ? WAIT : FETCH;
          end
        end

        WAIT: begin
          if (redirect) begin
            // Wrong-path word: drop it and keep the previous instr_out.
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else begin
            instr_out   <= mem_rdata;
            instr_pc    <= pc;
            pc          <= pc + PC_ONE;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (redirect) begin
            // Covers the ready=1 case too: the word counts as consumed and the
            // redirect still takes effect.
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. A behavioural synchronous memory with
// 1-cycle read latency feeds the DUT. Inputs change 1 time unit after each
// rising edge and outputs are compared at that same point, well away from the
// next active edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int WIDTH     = 16;
  localparam int ADDR_BITS = 16;

  logic                 clk;
  logic                 reset;
  logic                 fetch_en;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_rd_en;
  logic [WIDTH-1:0]     mem_rdata;
  logic                 redirect;
  logic [ADDR_BITS-1:0] redirect_pc;
  logic [WIDTH-1:0]     instr_out;
  logic [ADDR_BITS-1:0] instr_pc;
  logic [ADDR_BITS-1:0] instr_pc_plus1;
  logic                 instr_valid;
  logic                 instr_ready;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  instruction_fetch #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS),
    .RESET_PC (16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .mem_addr      (mem_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_rdata     (mem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_pc_plus1(instr_pc_plus1),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory model.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic exp_en, input logic [15:0] exp_addr);
    checks++;
    if (mem_rd_en !== exp_en || (exp_en && mem_addr !== exp_addr)) begin
      errors++;
      $display("FAIL %s: mem_rd_en=%0b mem_addr=%h, expected mem_rd_en=%0b mem_addr=%h",
               name, mem_rd_en, mem_addr, exp_en, exp_addr);
    end
  endtask

  task automatic chk_word(input string name, input logic exp_valid, input logic [15:0] exp_out,
                          input logic [15:0] exp_pc);
    checks++;
    if (instr_valid !== exp_valid || instr_out !== exp_out || instr_pc !== exp_pc) begin
      errors++;
      $display("FAIL %s: valid=%0b out=%h pc=%h, expected valid=%0b out=%h pc=%h",
               name, instr_valid, instr_out, instr_pc, exp_valid, exp_out, exp_pc);
    end
  endtask

  task automatic test_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    redirect_pc = '0;
    do_reset();
    reset = 1'b1;
    tick();
    chk_rd("reset_rd", 1'b0, 16'h0000);
    chk_word("reset_word", 1'b0, 16'h0000, 16'h0000);
    checks++;
    if (mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_addr: mem_addr=%h expected 0000", mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_fetch();
    mem[0] = 16'h0A12;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    tick();
    chk_rd("first_fetch_rd", 1'b1, 16'h0000);
    tick();
    chk_word("first_wait", 1'b0, 16'h0000, 16'h0000);
    tick();
    chk_word("first_word", 1'b1, 16'h0A12, 16'h0000);
    checks++;
    if (instr_pc_plus1 !== 16'h0001) begin
      errors++;
      $display("FAIL first_plus1: instr_pc_plus1=%h expected 0001", instr_pc_plus1);
    end
  endtask

  task automatic test_stream();
    logic [15:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    for (int i = 0; i < 4; i++) mem[i] = words[i];
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_rd($sformatf("stream_rd%0d", k), 1'b1, 16'(k));
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_gap%0d: instr_valid=%0b expected 0", k, instr_valid);
      end
      tick();
      tick();
      chk_word($sformatf("stream_word%0d", k), 1'b1, words[k], 16'(k));
    end
  endtask

  task automatic test_backpressure();
    // Memory still holds 0x1111..0x4444 at 0..3.
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    tick(); tick(); tick();    // HOLD with word 0
    tick();                    // FETCH addr 1
    tick();                    // WAIT
    instr_ready = 1'b0;
    tick();                    // HOLD with 0x2222
    for (int c = 0; c < 5; c++) begin
      chk_word($sformatf("bp_hold%0d", c), 1'b1, 16'h2222, 16'h0001);
      chk_rd($sformatf("bp_rd%0d", c), 1'b0, 16'h0000);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    chk_rd("bp_next_fetch", 1'b1, 16'h0002);
  endtask

  task automatic test_redirect_wait();
    mem[16'h0040] = 16'hC0DE;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    tick();                    // FETCH addr 0
    tick();                    // WAIT, 0x1111 arriving
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk_rd("rw_refetch", 1'b1, 16'h0040);
    chk_word("rw_discard", 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    chk_word("rw_word", 1'b1, 16'hC0DE, 16'h0040);
  endtask

  task automatic test_redirect_hold();
    mem[16'h0010] = 16'hBEEF;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    tick(); tick();
    instr_ready = 1'b0;
    tick();                    // HOLD with 0x1111
    chk_word("rh_hold", 1'b1, 16'h1111, 16'h0000);
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rh_drop: instr_valid=%0b expected 0", instr_valid);
    end
    chk_rd("rh_refetch", 1'b1, 16'h0010);
    tick(); tick();
    chk_word("rh_word", 1'b1, 16'hBEEF, 16'h0010);
    // Redirect and consume in the same cycle.
    instr_ready = 1'b1;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rh_ready_drop: instr_valid=%0b expected 0", instr_valid);
    end
    chk_rd("rh_ready_refetch", 1'b1, 16'h0010);
  endtask

  task automatic test_fetch_en();
    fetch_en = 1'b0;
    instr_ready = 1'b1;
    do_reset();
    tick();
    chk_rd("fe_idle", 1'b0, 16'h0000);
    fetch_en = 1'b1;
    tick();
    chk_rd("fe_fetch", 1'b1, 16'h0000);
    fetch_en = 1'b0;
    #1;
    chk_rd("fe_fetch_gated", 1'b0, 16'h0000);
    tick();
    chk_rd("fe_fetch_stall", 1'b0, 16'h0000);
    fetch_en = 1'b1;
    #1;
    chk_rd("fe_fetch_resume", 1'b1, 16'h0000);
    tick();                    // WAIT
    fetch_en = 1'b0;
    tick();
    chk_word("fe_wait_capture", 1'b1, 16'h1111, 16'h0000);
    fetch_en = 1'b1;
  endtask

  task automatic test_wrap_and_reset();
    mem[16'hFFFF] = 16'hFACE;
    mem[16'h0000] = 16'h1111;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();                    // IDLE: pc retargeted, go to FETCH
    redirect = 1'b0;
    chk_rd("wrap_fetch", 1'b1, 16'hFFFF);
    tick(); tick();
    chk_word("wrap_word", 1'b1, 16'hFACE, 16'hFFFF);
    checks++;
    if (instr_pc_plus1 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_plus1: instr_pc_plus1=%h expected 0000", instr_pc_plus1);
    end
    tick();
    chk_rd("wrap_next", 1'b1, 16'h0000);
    tick();                    // WAIT, word in flight
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_word("rst_wait_drop", 1'b0, 16'h0000, 16'h0000);
    chk_rd("rst_wait_idle", 1'b0, 16'h0000);
    tick();
    chk_rd("rst_wait_refetch", 1'b1, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_BITS); i++) mem[i] = 16'(i) ^ 16'h5A5A;
    reset = 1'b1;
    fetch_en = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    test_reset();
    test_first_fetch();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_fetch_en();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
